mux_n_stage: RTL and testbench

//  Registered N:1 select stage with valid/ready handshake, flush and select-range check.

---
 rtl/mux_n_stage_pkg.sv | 17 +
 rtl/mux_n_stage_if.sv | 27 ++
 rtl/mux_n_stage_skid.sv | 120 ++++++++++++
 rtl/mux_n_stage.sv | 63 ++++++
 tb/tb_mux_n_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_n_stage_pkg.sv
// Shared types and helpers for the registered N:1 select stage (mux_n_stage).
package mux_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_st_e;

    localparam int MIN_N_IN = 2;

    // True when a select index addresses a real source; out-of-range selects fall back to DEFAULT_IDX.
    function automatic logic sel_ok(input int unsigned sel, input int unsigned n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/mux_n_stage_if.sv
// Handshake/data bundle of mux_n_stage: upstream select/data/valid, downstream data/valid/ready, flush, sel_err.
interface mux_n_stage_if #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4
);
    localparam int SEL_W = $clog2(N_IN);

    logic [SEL_W-1:0]      sel;
    logic [N_IN*WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;

    modport master (
        output sel, in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  sel, in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/mux_n_stage_skid.sv
// Register/handshake core of mux_n_stage: main output register plus skid entry.
// Skid entry and the ST_SKID state exist only when MUX_STAGE_SKID_EN is defined.
module mux_stage_skid
    import mux_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    stage_st_e        state_r;
    stage_st_e        state_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic             load_main_s;
    logic             main_from_skid_s;
    logic             load_skid_s;
    logic             accept_s;
    logic             push_s;

    assign out_valid = (state_r != ST_EMPTY);
    assign out_data  = main_r;
`ifdef MUX_STAGE_SKID_EN
    // Ready comes straight from the state register, so it never waits on out_ready.
    assign in_ready  = (state_r != ST_SKID);
`else
    assign in_ready  = ~out_valid | out_ready;
`endif
    assign accept_s  = in_valid & in_ready;
    assign push_s    = out_valid & out_ready;

    // Next-state and register-load decode; flush wins over any accept.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_s      = 1'b0;
        main_from_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ST_FULL;
                        load_main_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_s && push_s) begin
                        state_nxt_s = ST_FULL;
                        load_main_s = 1'b1;
                    end else if (push_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else if (accept_s) begin
`ifdef MUX_STAGE_SKID_EN
                        state_nxt_s = ST_SKID;
                        load_skid_s = 1'b1;
`else
                        state_nxt_s = ST_FULL;
                        load_main_s = 1'b1;
`endif
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                ST_SKID: begin
`ifdef MUX_STAGE_SKID_EN
                    if (push_s) begin
                        state_nxt_s      = ST_FULL;
                        load_main_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_SKID;
                    end
`else
                    state_nxt_s = ST_EMPTY;
`endif
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Main and skid data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r <= {WIDTH{1'b0}};
            skid_r <= {WIDTH{1'b0}};
        end else begin
            if (load_main_s) begin
                main_r <= main_from_skid_s ? skid_r : in_word;
            end
            if (load_skid_s) begin
                skid_r <= in_word;
            end
        end
    end

endmodule

// File: rtl/mux_n_stage.sv
// Registered N:1 select stage: source decode with DEFAULT_IDX fallback, sel_err pulse, and
// the handshake core. MUX_STAGE_SKID_EN enables the skid entry (registered in_ready).
module mux_n_stage
    import mux_stage_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int N_IN        = 4,
    parameter int DEFAULT_IDX = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_n_stage_if.slave  bus
);

    logic [WIDTH-1:0] src_s [N_IN];
    logic [WIDTH-1:0] sel_word_s;
    logic             sel_in_range_s;
    logic             accept_s;
    logic             sel_err_r;

    for (genvar g = 0; g < N_IN; g++) begin : g_unpack
        assign src_s[g] = bus.in_data[g*WIDTH +: WIDTH];
    end

    // Source select; an out-of-range index reads the default source instead.
    always_comb begin
        sel_in_range_s = sel_ok(32'(bus.sel), 32'(N_IN));
        if (sel_in_range_s) begin
            sel_word_s = src_s[bus.sel];
        end else begin
            sel_word_s = src_s[DEFAULT_IDX];
        end
    end

    assign accept_s    = bus.in_valid & bus.in_ready;
    assign bus.sel_err = sel_err_r;

    // One-cycle error pulse for an accepted out-of-range select; flush suppresses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (bus.flush) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= accept_s & ~sel_in_range_s;
        end
    end

    mux_stage_skid #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .in_word   (sel_word_s),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

endmodule

// File: tb/tb_mux_n_stage.sv
// Scoreboard bench for mux_n_stage: an N_IN=4 instance for stream/backpressure/flush/reset and
// an N_IN=3 instance for the select-range fallback; expectations adapt to MUX_STAGE_SKID_EN.
module tb_mux_n_stage;

`ifdef MUX_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] exp_q[$];
    logic        exp_selerr4;

    always #5 clk = ~clk;

    mux_n_stage_if #(.WIDTH(32), .N_IN(4)) bus4 ();
    mux_n_stage_if #(.WIDTH(32), .N_IN(3)) bus3 ();

    mux_n_stage #(.WIDTH(32), .N_IN(4), .DEFAULT_IDX(0)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    mux_n_stage #(.WIDTH(32), .N_IN(3), .DEFAULT_IDX(0)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
        if (SKID) return (exp_q.size() < 2);
        else      return (exp_q.size() == 0) || bus4.out_ready;
    endfunction

    task automatic set_src4(input int k);
        for (int i = 0; i < 4; i++) begin
            bus4.in_data[i*32 +: 32] = 32'h0A00_0000 | (32'(k) << 8) | 32'(i);
        end
    endtask

    // One clock of the N_IN=4 instance: compare at the falling edge, update the model at the rising edge.
    task automatic tick4();
        logic        acc;
        logic        psh;
        logic [31:0] word;
        @(negedge clk);
        chk("in_ready", 32'(bus4.in_ready), 32'(model_ready()));
        chk("out_valid", 32'(bus4.out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("out_data", bus4.out_data, exp_q[0]);
        chk("sel_err4", 32'(bus4.sel_err), 32'(exp_selerr4));
        acc  = bus4.in_valid & model_ready();
        psh  = (exp_q.size() != 0) & bus4.out_ready;
        word = bus4.in_data[int'(bus4.sel)*32 +: 32];
        @(posedge clk);
        if (bus4.flush) begin
            exp_q.delete();
            exp_selerr4 = 1'b0;
        end else begin
            if (psh) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(word);
            exp_selerr4 = acc && (int'(bus4.sel) >= 4);
        end
        #1;
    endtask

    task automatic check_reset_vals(input string who, input logic ov, input logic [31:0] od,
                                    input logic se, input logic ir);
        chk({who, "_rst_out_valid"}, 32'(ov), 32'd0);
        chk({who, "_rst_out_data"}, od, 32'd0);
        chk({who, "_rst_sel_err"}, 32'(se), 32'd0);
        chk({who, "_rst_in_ready"}, 32'(ir), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_selerr4    = 1'b0;
        rst_n          = 1'b1;
        bus4.sel       = 2'd0;
        bus4.in_data   = 128'd0;
        bus4.in_valid  = 1'b0;
        bus4.flush     = 1'b0;
        bus4.out_ready = 1'b0;
        bus3.sel       = 2'd0;
        bus3.in_data   = 96'd0;
        bus3.in_valid  = 1'b0;
        bus3.flush     = 1'b0;
        bus3.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        check_reset_vals("dut4", bus4.out_valid, bus4.out_data, bus4.sel_err, bus4.in_ready);
        check_reset_vals("dut3", bus3.out_valid, bus3.out_data, bus3.sel_err, bus3.in_ready);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // Stream: sel cycles 0..3 at full rate
        for (int k = 0; k < 8; k++) begin
            set_src4(k);
            bus4.sel       = 2'(k % 4);
            bus4.in_valid  = 1'b1;
            bus4.out_ready = 1'b1;
            tick4();
        end
        bus4.in_valid = 1'b0;
        tick4();
        tick4();

        // Backpressure for three cycles, then release with upstream still offering
        for (int k = 8; k < 11; k++) begin
            set_src4(k);
            bus4.sel       = 2'(k % 4);
            bus4.in_valid  = 1'b1;
            bus4.out_ready = 1'b0;
            tick4();
        end
        for (int k = 11; k < 13; k++) begin
            set_src4(k);
            bus4.sel       = 2'(3 - (k % 4));
            bus4.out_ready = 1'b1;
            tick4();
        end
        bus4.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick4();

        // Flush with a simultaneous offer while holding data
        for (int k = 13; k < 15; k++) begin
            set_src4(k);
            bus4.sel       = 2'(k % 4);
            bus4.in_valid  = 1'b1;
            bus4.out_ready = 1'b0;
            tick4();
        end
        set_src4(15);
        bus4.flush = 1'b1;
        tick4();
        bus4.flush    = 1'b0;
        bus4.in_valid = 1'b0;
        tick4();
        tick4();

        // Flush together with a downstream push
        set_src4(16);
        bus4.sel       = 2'd2;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;
        tick4();
        set_src4(17);
        bus4.flush = 1'b1;
        tick4();
        bus4.flush    = 1'b0;
        bus4.in_valid = 1'b0;
        tick4();

        // Mid-stream reset while holding words
        for (int k = 18; k < 20; k++) begin
            set_src4(k);
            bus4.sel       = 2'(k % 4);
            bus4.in_valid  = 1'b1;
            bus4.out_ready = 1'b0;
            tick4();
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("dut4_mid", bus4.out_valid, bus4.out_data, bus4.sel_err, bus4.in_ready);
        exp_q.delete();
        exp_selerr4   = 1'b0;
        bus4.in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        tick4();

        // Range check on N_IN=3: sel=3 falls back to source 0 and pulses sel_err
        bus3.in_data   = {32'h3333_0002, 32'h2222_0001, 32'hDEAD_BEEF};
        bus3.sel       = 2'd3;
        bus3.in_valid  = 1'b1;
        bus3.out_ready = 1'b1;
        @(posedge clk) #1;
        bus3.sel = 2'd2;
        @(negedge clk);
        chk("range_out_valid", 32'(bus3.out_valid), 32'd1);
        chk("range_out_data", bus3.out_data, 32'hDEAD_BEEF);
        chk("range_sel_err", 32'(bus3.sel_err), 32'd1);
        @(posedge clk) #1;
        bus3.in_valid = 1'b0;
        @(negedge clk);
        chk("top_idx_out_data", bus3.out_data, 32'h3333_0002);
        chk("top_idx_sel_err", 32'(bus3.sel_err), 32'd0);
        @(posedge clk) #1;
        @(negedge clk);
        chk("range_drain_valid", 32'(bus3.out_valid), 32'd0);
        chk("range_drain_sel_err", 32'(bus3.sel_err), 32'd0);

        // Reset while sel_err is high clears it at once
        bus3.sel       = 2'd3;
        bus3.in_valid  = 1'b1;
        bus3.out_ready = 1'b0;
        @(posedge clk) #1;
        bus3.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_sel_err", 32'(bus3.sel_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("dut3_mid", bus3.out_valid, bus3.out_data, bus3.sel_err, bus3.in_ready);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
